aes_inv_key_sched: RTL

//  Inverse AES-128 key schedule: takes the final (round-10) round key and walks the

---
 rtl/aes_inv_key_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : aes_4sbox, aes_inv_key_sched
//  Purpose  : Inverse AES-128 key schedule. A round-LAST_ROUND key is loaded
//             on start, and the schedule is then walked backwards one round
//             per accepted valid/ready handshake. Keys LAST_ROUND..0 are
//             emitted in that order for the decryption datapath.
//  Ports (aes_inv_key_sched):
//    clk        in   1    clock, rising edge
//    reset_n    in   1    asynchronous active-low reset
//    start      in   1    load last_key and begin a sweep (ignored while busy)
//    last_key   in   128  round-LAST_ROUND key {w0,w1,w2,w3}, w0 = [127:96]
//    key_valid  out  1    round_key/key_round hold a valid key
//    key_ready  in   1    consumer accepts when key_valid && key_ready
//    round_key  out  128  current round key {w0,w1,w2,w3}
//    key_round  out  4    round index of round_key
//    busy       out  1    sweep in progress
//    done       out  1    one-cycle pulse after the round-0 key is accepted
//  Ports (aes_4sbox):
//    din        in   32   four input bytes
//    dout       out  32   AES S-box applied to each byte independently
//  Revision : 1.0  initial release
// ============================================================================

// Four parallel AES S-boxes. Each byte is mapped through the GF(2^8)
// multiplicative inverse followed by the FIPS-197 affine transform, which
// keeps the table out of the source while remaining purely combinational.
module aes_4sbox (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc_a;
        prod  = 8'h00;
        acc_a = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ acc_a;
            end
            acc_a = {acc_a[6:0], 1'b0} ^ (acc_a[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

    // x^254 == x^-1 for x != 0; the chain naturally maps 0 to 0 as AES needs.
    // x^254 = x^2 * x^4 * ... * x^128, built by repeated squaring.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        // Affine map: b ^ rotl(b,1) ^ rotl(b,2) ^ rotl(b,3) ^ rotl(b,4) ^ 0x63
        return v
             ^ {v[6:0], v[7]}
             ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]}
             ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign dout[8*g +: 8] = sbox(din[8*g +: 8]);
    end

endmodule

// LAST_ROUND is the round index of the loaded key; legal range is 1..10.
module aes_inv_key_sched #(
    parameter int LAST_ROUND = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   key_round,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] C_LAST_ROUND = 4'(LAST_ROUND);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_round_key;
    logic [3:0]   r_key_round;
    logic         r_done;

    logic         w_handshake;
    logic         w_final;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_sub;
    logic [127:0] w_prev_key;

    // Round constant of the round being undone; same table as the forward
    // expander uses for producing round r from round r-1.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] val;
        case (r)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    assign w_handshake = (r_state == ST_EMIT) && key_ready;
    assign w_final     = (r_key_round == 4'd0);

    // Undo one forward round. The forward step makes each word the XOR of
    // its predecessor in the new key and the same word in the old key, so
    // XORing adjacent new words recovers w1..w3 directly; w0 then needs the
    // recovered old w3 (p3) through RotWord(SubWord()) plus rcon.
    assign {w_w0, w_w1, w_w2, w_w3} = r_round_key;
    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;

    aes_4sbox u_sbox (
        .din  (w_p3),
        .dout (w_sub)
    );

    assign w_p0       = w_w0 ^ {w_sub[23:0], w_sub[31:24]} ^ {rcon(r_key_round), 24'h000000};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_handshake && w_final) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The key register only moves on load or on a non-final handshake, so a
    // stalled key holds and the round-0 key remains visible after the sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_round_key <= 128'h0;
            r_key_round <= 4'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_handshake && w_final;
            if ((r_state == ST_IDLE) && start) begin
                r_round_key <= last_key;
                r_key_round <= C_LAST_ROUND;
            end else if (w_handshake && !w_final) begin
                r_round_key <= w_prev_key;
                r_key_round <= r_key_round - 4'd1;
            end
        end
    end

    assign key_valid = (r_state == ST_EMIT);
    assign busy      = (r_state == ST_EMIT);
    assign round_key = r_round_key;
    assign key_round = r_key_round;
    assign done      = r_done;

endmodule

`default_nettype wire
